// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads versus posted CA-core writes.
// Reads win unless a write has waited through MAX_RD_STREAK consecutive read grants.
module vram_arbiter #(
    parameter int AVN_AW        = 19,
    parameter int AVN_DW        = 16,
    parameter int WFIFO_DEPTH   = 4,
    parameter int RD_LAT        = 1,
    parameter int MAX_RD_STREAK = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              rd_avn_read,
    input  logic [AVN_AW-1:0] rd_avn_address,
    output logic              rd_avn_waitrequest,
    output logic [AVN_DW-1:0] rd_avn_readdata,
    output logic              rd_avn_readdatavalid,
    input  logic              wr_avn_write,
    input  logic [AVN_AW-1:0] wr_avn_address,
    input  logic [AVN_DW-1:0] wr_avn_writedata,
    output logic              wr_avn_waitrequest,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AVN_AW-1:0] mem_addr,
    output logic [AVN_DW-1:0] mem_wdata,
    input  logic [AVN_DW-1:0] mem_rdata
);

    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_RD_STREAK + 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(WFIFO_DEPTH);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE
    } gnt_e;

    gnt_e gnt;

    logic [AVN_AW+AVN_DW-1:0] fifo_q [WFIFO_DEPTH];
    logic [PW-1:0]            wptr_q, wptr_d;
    logic [PW-1:0]            rptr_q, rptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [SW-1:0]            streak_q, streak_d;
    logic [RD_LAT-1:0]        vld_q, vld_d;

    logic              full, wr_pend, push, pop, rd_gnt;
    logic [AVN_AW-1:0] head_addr;
    logic [AVN_DW-1:0] head_data;

    assign {head_addr, head_data} = fifo_q[rptr_q];
    assign full    = (count_q == FIFO_FULL);
    assign wr_pend = (count_q != '0);

    always_comb begin
        gnt = GNT_IDLE;
        if (!sys_rst) begin
            if (rd_avn_read && (!wr_pend || streak_q < STREAK_MAX)) begin
                gnt = GNT_READ;
            end else if (wr_pend) begin
                gnt = GNT_WRITE;
            end
        end
    end

    assign rd_gnt = (gnt == GNT_READ);
    assign pop    = (gnt == GNT_WRITE);
    assign push   = wr_avn_write && !full && !sys_rst;

    // During reset the read port stalls and everything else looks idle.
    assign rd_avn_waitrequest   = sys_rst || (rd_avn_read && !rd_gnt);
    assign wr_avn_waitrequest   = !sys_rst && full;
    assign mem_req              = (gnt != GNT_IDLE);
    assign mem_we               = pop;
    assign mem_addr             = pop ? head_addr : rd_avn_address;
    assign mem_wdata            = head_data;
    assign rd_avn_readdata      = mem_rdata;
    assign rd_avn_readdatavalid = vld_q[RD_LAT-1] && !sys_rst;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        if (pop || !wr_pend) begin
            streak_d = '0;
        end else if (rd_gnt && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    if (RD_LAT > 1) begin : g_vld_pipe
        assign vld_d = {vld_q[RD_LAT-2:0], rd_gnt};
    end else begin : g_vld_single
        assign vld_d = rd_gnt;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            streak_q <= '0;
            vld_q    <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            streak_q <= streak_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_q[wptr_q] <= {wr_avn_address, wr_avn_writedata};
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter with a behavioural memory and reference model.
module tb_vram_arbiter;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int N_CA_WR = 3000;
    localparam logic [AW-1:0] WR_BASE = 19'h40000;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          rd_avn_read;
    logic [AW-1:0] rd_avn_address;
    logic          rd_avn_waitrequest;
    logic [DW-1:0] rd_avn_readdata;
    logic          rd_avn_readdatavalid;
    logic          wr_avn_write;
    logic [AW-1:0] wr_avn_address;
    logic [DW-1:0] wr_avn_writedata;
    logic          wr_avn_waitrequest;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 sys_clk = ~sys_clk;

    vram_arbiter #(
        .AVN_AW(AW), .AVN_DW(DW), .WFIFO_DEPTH(4), .RD_LAT(1), .MAX_RD_STREAK(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rd_avn_read(rd_avn_read), .rd_avn_address(rd_avn_address),
        .rd_avn_waitrequest(rd_avn_waitrequest), .rd_avn_readdata(rd_avn_readdata),
        .rd_avn_readdatavalid(rd_avn_readdatavalid),
        .wr_avn_write(wr_avn_write), .wr_avn_address(wr_avn_address),
        .wr_avn_writedata(wr_avn_writedata), .wr_avn_waitrequest(wr_avn_waitrequest),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s: event not expected here", name);
    endtask

    // Unwritten locations hold a fixed pattern of their address.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[15:0] ^ {a[18:16], 13'h1A5};
    endfunction

    // Behavioural single-port RAM, one-cycle registered read.
    logic [DW-1:0] stub [logic [AW-1:0]];
    always @(posedge sys_clk) begin
        if (mem_req && mem_we) stub[mem_addr] = mem_wdata;
        if (mem_req && !mem_we) mem_rdata <= stub.exists(mem_addr) ? stub[mem_addr] : pat(mem_addr);
    end

    // Reference: memory contents as seen in acceptance order; reads never hit pending writes.
    logic [DW-1:0]    ref_mem [logic [AW-1:0]];
    logic [DW-1:0]    rdq [$];
    logic [AW+DW-1:0] wrq [$];
    logic [DW-1:0]    mon_rd;
    logic [AW+DW-1:0] mon_wr;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            rdq.delete();
            wrq.delete();
        end else begin
            if (rd_avn_readdatavalid) begin
                if (rdq.size() == 0) fail("rd_unexpected");
                else begin
                    mon_rd = rdq.pop_front();
                    check("rd_data", rd_avn_readdata, mon_rd);
                end
            end
            if (mem_req && mem_we) begin
                if (wrq.size() == 0) fail("wr_unexpected");
                else begin
                    mon_wr = wrq.pop_front();
                    check("wr_issue", {mem_addr, mem_wdata}, mon_wr);
                end
            end
            if (rd_avn_read && !rd_avn_waitrequest)
                rdq.push_back(ref_mem.exists(rd_avn_address) ? ref_mem[rd_avn_address] : pat(rd_avn_address));
            if (wr_avn_write && !wr_avn_waitrequest) begin
                ref_mem[wr_avn_address] = wr_avn_writedata;
                wrq.push_back({wr_avn_address, wr_avn_writedata});
            end
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain(input string name);
        int unsigned k;
        rd_avn_read  = 1'b0;
        wr_avn_write = 1'b0;
        k = 0;
        while ((rdq.size() != 0 || wrq.size() != 0 || mem_req) && k < 100) begin
            step();
            k++;
        end
        step();
        if (k >= 100) fail(name);
    endtask

    function automatic logic [AW-1:0] rd_rand();
        return AW'($urandom_range(0, 32'h3FFFF));
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_pop, wait_cyc, acc5, rdw_cnt, k, waits, pulses, wacc, mwe, mrdv, mreq;
        logic w_hold, r_hold;
        sys_rst = 1'b1;
        rd_avn_read = 1'b0;  rd_avn_address = '0;
        wr_avn_write = 1'b0; wr_avn_address = '0; wr_avn_writedata = '0;

        // Reset values, during and after reset
        step(); step();
        @(negedge sys_clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_rdv", rd_avn_readdatavalid, 0);
        check("rst_wr_wait", wr_avn_waitrequest, 0);
        check("rst_rd_wait", rd_avn_waitrequest, 1);
        step(); sys_rst = 1'b0;
        @(negedge sys_clk);
        check("post_rst_mem_req", mem_req, 0);
        check("post_rst_rdv", rd_avn_readdatavalid, 0);
        check("post_rst_rd_wait", rd_avn_waitrequest, 0);

        // Single read of 0x00010
        step(); rd_avn_read = 1'b1; rd_avn_address = 19'h00010;
        @(negedge sys_clk);
        check("rd1_grant", {mem_req, mem_we, rd_avn_waitrequest, rd_avn_readdatavalid}, 4'b1000);
        check("rd1_addr", mem_addr, 19'h00010);
        step(); rd_avn_read = 1'b0;
        @(negedge sys_clk);
        check("rd1_valid", rd_avn_readdatavalid, 1);

        // Write posting, then read it back once drained
        step(); wr_avn_write = 1'b1; wr_avn_address = 19'h00005; wr_avn_writedata = 16'hFFFF;
        @(negedge sys_clk);
        check("wr_no_bypass", mem_req, 0);
        step(); wr_avn_write = 1'b0;
        @(negedge sys_clk);
        check("wr_issue_cyc", {mem_req, mem_we}, 2'b11);
        check("wr_issue_addr", mem_addr, 19'h00005);
        check("wr_issue_data", mem_wdata, 16'hFFFF);
        step(); rd_avn_read = 1'b1; rd_avn_address = 19'h00005;
        step(); rd_avn_read = 1'b0;
        @(negedge sys_clk);
        check("rb_valid", rd_avn_readdatavalid, 1);
        check("rb_data", rd_avn_readdata, 16'hFFFF);
        drain("drain_t2");

        // FIFO full with reads held high: 8 read grants then one write grant
        first_pop = -1; wait_cyc = 0; acc5 = -1; rdw_cnt = 0; k = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            rd_avn_read = 1'b1; rd_avn_address = rd_rand();
            wr_avn_write = (k < 5);
            wr_avn_address = WR_BASE + AW'(k); wr_avn_writedata = 16'(16'hA000 + k);
            @(negedge sys_clk);
            if (mem_req && mem_we && first_pop < 0) first_pop = c;
            if (rd_avn_waitrequest) rdw_cnt++;
            if (k == 4 && wr_avn_waitrequest) wait_cyc++;
            if (wr_avn_write && !wr_avn_waitrequest) begin
                if (k == 4) acc5 = c;
                k++;
            end
        end
        check("full_first_pop", first_pop, 9);
        check("full_wait_cycles", wait_cyc, 6);
        check("full_acc5_cycle", acc5, 10);
        check("full_rd_wait_cnt", rdw_cnt, 1);
        drain("drain_t3");

        // 640 back-to-back reads
        waits = 0; pulses = 0;
        for (int c = 0; c < 645; c++) begin
            step();
            rd_avn_read = (c < 640); rd_avn_address = AW'(c);
            @(negedge sys_clk);
            if (rd_avn_read && rd_avn_waitrequest) waits++;
            if (rd_avn_readdatavalid) pulses++;
        end
        check("stream_waits", waits, 0);
        check("stream_pulses", pulses, 640);
        drain("drain_t4");

        // CA-core-like stream: sequential writes under random 2-of-3 reads
        wacc = 0; w_hold = 1'b0; r_hold = 1'b0;
        for (int c = 0; c < 30000 && wacc < N_CA_WR; c++) begin
            step();
            wr_avn_write = 1'b1;
            wr_avn_address = WR_BASE + AW'(wacc);
            if (!w_hold) wr_avn_writedata = DW'($urandom);
            if (!r_hold) begin
                rd_avn_read = ($urandom_range(2) != 0);
                rd_avn_address = rd_rand();
            end
            @(negedge sys_clk);
            if (!wr_avn_waitrequest) wacc++;
            w_hold = wr_avn_waitrequest;
            r_hold = rd_avn_read && rd_avn_waitrequest;
        end
        check("ca_all_accepted", wacc, N_CA_WR);
        drain("drain_t5");
        check("ca_rdq_empty", rdq.size(), 0);
        check("ca_wrq_empty", wrq.size(), 0);

        // Reset with 3 writes queued and a read in flight
        for (int c = 0; c < 4; c++) begin
            step();
            rd_avn_read = 1'b1; rd_avn_address = rd_rand();
            wr_avn_write = (c < 3);
            wr_avn_address = WR_BASE + 19'h100 + AW'(c); wr_avn_writedata = 16'h5500;
        end
        @(negedge sys_clk);
        check("mid_no_wr_before_rst", mem_we && mem_req, 0);
        step(); sys_rst = 1'b1; rd_avn_read = 1'b0; wr_avn_write = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_rdv", rd_avn_readdatavalid, 0);
        step(); step(); sys_rst = 1'b0;
        mwe = 0; mrdv = 0; mreq = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge sys_clk);
            if (mem_req && mem_we) mwe++;
            if (mem_req) mreq++;
            if (rd_avn_readdatavalid) mrdv++;
            step();
        end
        check("mid_post_wr", mwe, 0);
        check("mid_post_req", mreq, 0);
        check("mid_post_rdv", mrdv, 0);
        check("mid_post_wr_wait", wr_avn_waitrequest, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
